// File: rtl/spi_rx_buffer.sv
// SPI mode-0 slave receiver feeding a 32-byte buffer that the serial transmitter drains by address.
// Optional sticky OVERRUN flag/port is built when SPI_RX_OVERRUN_EN is defined.
module spi_rx_buffer #(
    parameter int MSB_FIRST = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       CS_N,
    input  logic [4:0] ADDR,
    output logic [7:0] BYTEOUT,
    output logic       READY,
    input  logic       CLEAR,
    output logic       FRAME_ERR
`ifdef SPI_RX_OVERRUN_EN
    ,
    output logic       OVERRUN
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    logic       sck_s1_q, sck_s2_q, sck_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic       cs_s1_q, cs_s2_q, cs_s3_q;
    logic       sck_rise_s, cs_rise_s;

    logic [7:0] shift_q, shift_d, shifted_s;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       frame_err_q, frame_err_d;
    logic       byte_valid_s;

    state_e     state_q;
    logic [5:0] wptr_q;
    logic       ready_q;
    logic       mem_we_s;
    logic [7:0] mem_q [32];

    // Synchronisers; flops park at 1 so reset never fakes an SCK or CS_N edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sck_s1_q  <= 1'b1;
            sck_s2_q  <= 1'b1;
            sck_s3_q  <= 1'b1;
            mosi_s1_q <= 1'b1;
            mosi_s2_q <= 1'b1;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
        end else begin
            sck_s1_q  <= SCK;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
            cs_s1_q   <= CS_N;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
        end
    end

    assign sck_rise_s = sck_s2_q & ~sck_s3_q;
    assign cs_rise_s  = cs_s2_q & ~cs_s3_q;
    assign shifted_s  = (MSB_FIRST != 0) ? {shift_q[6:0], mosi_s2_q}
                                         : {mosi_s2_q, shift_q[7:1]};

    // Bit assembly: a deselect mid-byte discards the partial byte and flags a framing error.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        frame_err_d  = 1'b0;
        byte_valid_s = 1'b0;
        if (cs_s2_q) begin
            bit_cnt_d   = 3'd0;
            frame_err_d = cs_rise_s && (bit_cnt_q != 3'd0);
        end else if (sck_rise_s) begin
            shift_d      = shifted_s;
            bit_cnt_d    = bit_cnt_q + 3'd1;
            byte_valid_s = (bit_cnt_q == 3'd7);
        end else begin
            shift_d = shift_q;
        end
    end

    // Bit assembly state registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Buffer FSM: CLEAR low always wins and restarts filling from address 0.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= FILL;
            wptr_q  <= 6'd0;
            ready_q <= 1'b0;
        end else if (!CLEAR) begin
            state_q <= FILL;
            wptr_q  <= 6'd0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (wptr_q == 6'd32) begin
                        state_q <= FULL;
                        ready_q <= 1'b1;
                    end else if (byte_valid_s) begin
                        wptr_q <= wptr_q + 6'd1;
                    end
                end
                FULL: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= FILL;
                    wptr_q  <= 6'd0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // wptr[5] also blocks the single cycle where wptr is 32 but the FSM is still in FILL.
    assign mem_we_s = RESET & CLEAR & byte_valid_s & (state_q == FILL) & ~wptr_q[5];

    // Byte storage; contents intentionally survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[wptr_q[4:0]] <= shifted_s;
        end
    end

`ifdef SPI_RX_OVERRUN_EN
    logic overrun_q;

    // Sticky record of any received byte that could not be stored.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            overrun_q <= 1'b0;
        end else if (byte_valid_s && (!CLEAR || (state_q == FULL) || wptr_q[5])) begin
            overrun_q <= 1'b1;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    assign OVERRUN = overrun_q;
`endif

    assign BYTEOUT   = mem_q[ADDR];
    assign READY     = ready_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Scoreboard bench for spi_rx_buffer: MSB-first and LSB-first instances share one SPI stream.
module tb_spi_rx_buffer;

    logic       clk = 1'b0;
    logic       rst_n, sck, mosi, cs_n, clear;
    logic [4:0] addr;
    logic [7:0] byteout, byteout_l;
    logic       ready, ready_l, frame_err, frame_err_l;
`ifdef SPI_RX_OVERRUN_EN
    logic       overrun, overrun_l;
`endif

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         fe_base;
    logic [7:0] sb_q [$];
    logic [7:0] exp_mem [32];
    logic [7:0] rnd;

    always #5 clk = ~clk;

    spi_rx_buffer #(.MSB_FIRST(1)) dut (
        .CLK(clk), .RESET(rst_n), .SCK(sck), .MOSI(mosi), .CS_N(cs_n),
        .ADDR(addr), .BYTEOUT(byteout), .READY(ready), .CLEAR(clear),
        .FRAME_ERR(frame_err)
`ifdef SPI_RX_OVERRUN_EN
        , .OVERRUN(overrun)
`endif
    );

    spi_rx_buffer #(.MSB_FIRST(0)) dut_lsb (
        .CLK(clk), .RESET(rst_n), .SCK(sck), .MOSI(mosi), .CS_N(cs_n),
        .ADDR(addr), .BYTEOUT(byteout_l), .READY(ready_l), .CLEAR(clear),
        .FRAME_ERR(frame_err_l)
`ifdef SPI_RX_OVERRUN_EN
        , .OVERRUN(overrun_l)
`endif
    );

    // Count framing-error pulse cycles.
    always @(posedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits go out first-to-last as b[7]..b[0]; SCK = CLK/8.
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sck  = 1'b0;
            mosi = b[7-i];
            tick(4);
            sck = 1'b1;
            tick(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cs_n = 1'b0;
        tick(4);
        spi_bits(b, 8);
        sck = 1'b0;
        tick(4);
        cs_n = 1'b1;
        tick(4);
    endtask

    task automatic send_store(input logic [7:0] b);
        sb_q.push_back(b);
        send_byte(b);
    endtask

    task automatic readback(input string tag);
        logic [7:0] e;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            exp_mem[a] = e;
            check_eq(tag, {24'd0, byteout}, {24'd0, e});
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b0;
        tick(1);
        clear = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; clear = 1'b1; addr = 5'd0;
        tick(5);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
`ifdef SPI_RX_OVERRUN_EN
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
`endif
        rst_n = 1'b1;
        tick(2);

        // Fill with 0x00..0x1F.
        for (int i = 0; i < 31; i++) send_store(8'(i));
        check_eq("ready_at_31", {31'd0, ready}, 32'd0);
        send_store(8'h1F);
        check_eq("ready_at_32", {31'd0, ready}, 32'd1);
        addr = 5'd5; #1;
        check_eq("addr5", {24'd0, byteout}, 32'h05);
        addr = 5'd31; #1;
        check_eq("addr31", {24'd0, byteout}, 32'h1F);
        readback("fill1");

        // CLEAR drains, then new bytes restart at address 0.
        pulse_clear();
        check_eq("clear_ready", {31'd0, ready}, 32'd0);
        send_store(8'hA5);
        addr = 5'd0; #1;
        check_eq("mem0_a5", {24'd0, byteout}, 32'hA5);
        check_eq("ready_after_a5", {31'd0, ready}, 32'd0);

        // Partial byte aborted by CS_N, then a clean byte.
        fe_base = fe_cnt;
        cs_n = 1'b0;
        tick(4);
        spi_bits(8'hFF, 5);
        sck = 1'b0;
        cs_n = 1'b1;
        tick(8);
        check_eq("frame_err_pulse", 32'(fe_cnt - fe_base), 32'd1);
        send_store(8'h3C);
        check_eq("frame_err_once", 32'(fe_cnt - fe_base), 32'd1);
        addr = 5'd1; #1;
        check_eq("mem1_3c", {24'd0, byteout}, 32'h3C);
        addr = 5'd2; #1;
        check_eq("mem2_old", {24'd0, byteout}, 32'h02);

        // First bit 1 then seven 0s: 0x80 MSB-first, 0x01 LSB-first.
        send_store(8'h80);
        addr = 5'd2; #1;
        check_eq("lsb_first", {24'd0, byteout_l}, 32'h01);
        for (int i = 3; i < 32; i++) begin
            rnd = 8'($urandom_range(255, 0));
            send_store(rnd);
        end
        check_eq("ready_fill2", {31'd0, ready}, 32'd1);
        readback("fill2");

        // Byte arriving while full is dropped.
        send_byte(8'hFF);
        check_eq("ready_hold", {31'd0, ready}, 32'd1);
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            check_eq("full_drop", {24'd0, byteout}, {24'd0, exp_mem[a]});
        end
`ifdef SPI_RX_OVERRUN_EN
        check_eq("overrun_set", {31'd0, overrun}, 32'd1);
`endif
        pulse_clear();
        check_eq("clear_ready2", {31'd0, ready}, 32'd0);
`ifdef SPI_RX_OVERRUN_EN
        check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);
`endif

        // Reset during the 20th byte discards the partial fill.
        for (int i = 0; i < 19; i++) send_byte(8'(8'hE0 + i));
        cs_n = 1'b0;
        tick(4);
        spi_bits(8'hC3, 4);
        rst_n = 1'b0;
        sck   = 1'b0;
        cs_n  = 1'b1;
        tick(3);
        check_eq("midrst_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        tick(4);
`ifdef SPI_RX_OVERRUN_EN
        check_eq("overrun_rst", {31'd0, overrun}, 32'd0);
`endif
        for (int i = 0; i < 31; i++) begin
            rnd = 8'($urandom_range(255, 0));
            send_store(rnd);
        end
        check_eq("ready_fresh31", {31'd0, ready}, 32'd0);
        send_store(8'h5A);
        check_eq("ready_fresh32", {31'd0, ready}, 32'd1);
        readback("fill3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
